// File: rtl/elastic_pipe_pkg.sv
// ---------------------------------------------------------------------------
// elastic_pipe_pkg
// Shared constants and helpers for the elastic valid/ready pipeline.
//   MAX_STAGE  : largest supported number of register stages
//   MAX_WIDTH  : largest supported payload width
//   cnt_width  : width of the occupancy counter for a given stage count
// ---------------------------------------------------------------------------
package elastic_pipe_pkg;

    localparam int MAX_STAGE = 64;
    localparam int MAX_WIDTH = 1024;

    // The occupancy counter must be able to hold 0..stage. A zero-stage pipe
    // still exposes a one-bit occupancy port, so the width never drops below 1.
    function automatic int cnt_width(input int stage);
        int w;
        w = $clog2(stage + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
// One valid/data register slot of the elastic pipeline.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : synchronous clear of the valid bit
//   load       : stage is ready, so it takes whatever the upstream offers
//   in_valid   : upstream valid (s_valid for the first stage)
//   in_data    : upstream payload
//   valid_q    : registered valid bit of this stage
//   data_q     : registered payload of this stage
// ---------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // The valid bit follows the upstream valid whenever the stage is ready,
    // which is how bubbles move forward and get squeezed out. Flush wins over
    // any load so nothing captured in a flush cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= in_valid;
        end
    end

    // The payload only moves when a real item is captured, so an idle stage
    // keeps its last value instead of toggling on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load && in_valid && !flush) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// ---------------------------------------------------------------------------
// elastic_pipe
// A chain of STAGE valid/ready register slots with bubble collapsing, flush
// and an occupancy counter. STAGE = 0 degenerates into a plain wire.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush               : synchronous discard of all in-flight items
//   s_valid/s_ready     : upstream handshake, s_data is the payload
//   m_valid/m_ready     : downstream handshake, m_data is the payload
//   occupancy           : registered count of valid stages
// ---------------------------------------------------------------------------
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int STAGE = 2,
    localparam int CNT_W = cnt_width(STAGE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] occupancy
);

    // Out-of-range parameters stop elaboration rather than building a
    // silently broken pipe.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("elastic_pipe: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (STAGE < 0 || STAGE > MAX_STAGE) begin : g_bad_stage
        $error("elastic_pipe: STAGE %0d outside 0..%0d", STAGE, MAX_STAGE);
    end

    if (STAGE == 0) begin : g_wire

        // With no registers the handshake passes straight through and flush
        // has nothing to clear.
        assign s_ready   = m_ready;
        assign m_valid   = s_valid;
        assign m_data    = s_data;
        assign occupancy = '0;

    end else begin : g_pipe

        logic [STAGE:1]   valid_q;
        logic [WIDTH-1:0] data_q [1:STAGE];
        logic [STAGE:1]   rdy;
        logic             in_xfer;
        logic             out_xfer;

        for (genvar k = 1; k <= STAGE; k++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;

            if (k == 1) begin : g_head
                assign up_valid = s_valid;
                assign up_data  = s_data;
            end else begin : g_body
                assign up_valid = valid_q[k-1];
                assign up_data  = data_q[k-1];
            end

            // Unrolled form of rdy[k] = !valid_q[k] || rdy[k+1]: a stage can
            // load if downstream is accepting or any slot from here to the
            // output is empty. Reading only registers avoids a long
            // combinational chain through rdy itself.
            assign rdy[k] = m_ready || !(&valid_q[STAGE:k]);

            pipe_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (flush),
                .load    (rdy[k]),
                .in_valid(up_valid),
                .in_data (up_data),
                .valid_q (valid_q[k]),
                .data_q  (data_q[k])
            );
        end

        assign s_ready  = rdy[1] && !flush;
        assign m_valid  = valid_q[STAGE];
        assign m_data   = data_q[STAGE];
        assign in_xfer  = s_valid && s_ready;
        assign out_xfer = m_valid && m_ready;

        // Occupancy tracks the number of set valid bits incrementally from
        // the two handshakes; simultaneous in and out leave it unchanged.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                occupancy <= '0;
            end else if (flush) begin
                occupancy <= '0;
            end else if (in_xfer && !out_xfer) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (!in_xfer && out_xfer) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end

    end

endmodule

// File: tb/tb_elastic_pipe.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipe
// Drives a STAGE=3 pipe and a STAGE=0 pipe from the same stimulus and checks
// them against a queue-based reference: items in flight, in order.
// ---------------------------------------------------------------------------
module tb_elastic_pipe;

    localparam int W  = 8;
    localparam int ST = 3;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         m_ready;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   occupancy;
    logic         s_ready0;
    logic         m_valid0;
    logic [W-1:0] m_data0;
    logic [0:0]   occupancy0;

    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] sb [$];
    logic         prev_hold  = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         last_in    = 1'b0;
    int           acc        = 0;

    elastic_pipe #(.WIDTH(W), .STAGE(ST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .occupancy(occupancy)
    );

    elastic_pipe #(.WIDTH(W), .STAGE(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_ready  (s_ready0),
        .s_data   (s_data),
        .m_valid  (m_valid0),
        .m_ready  (m_ready),
        .m_data   (m_data0),
        .occupancy(occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sv, input logic [W-1:0] sd,
                                 input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check mid-low-phase,
    // then advance the reference on the rising edge using the handshakes.
    task automatic stepCycle(input logic sv, input logic [W-1:0] sd,
                             input logic mr, input logic fl,
                             input int exp_mv, input int exp_md);
        logic in_x;
        logic out_x;
        @(negedge clk);
        applyStimulus(sv, sd, mr, fl);
        #1;
        checkOutput("s_ready", 32'(s_ready), 32'((sb.size() < ST || mr) && !fl));
        checkOutput("occupancy", 32'(occupancy), 32'(sb.size()));
        if (sb.size() == ST) checkOutput("m_valid_full", 32'(m_valid), 32'd1);
        if (sb.size() == 0) checkOutput("m_valid_empty", 32'(m_valid), 32'd0);
        if (m_valid && sb.size() > 0) checkOutput("m_data_order", 32'(m_data), 32'(sb[0]));
        if (prev_hold) begin
            checkOutput("hold_valid", 32'(m_valid), 32'd1);
            checkOutput("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (exp_mv >= 0) checkOutput("lat_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_md >= 0) checkOutput("lat_data", 32'(m_data), 32'(exp_md));
        checkOutput("wire_data", 32'(m_data0), 32'(sd));
        checkOutput("wire_valid", 32'(m_valid0), 32'(sv));
        checkOutput("wire_ready", 32'(s_ready0), 32'(mr));
        checkOutput("wire_occ", 32'(occupancy0), 32'd0);
        in_x      = sv && s_ready;
        out_x     = m_valid && mr;
        prev_hold = m_valid && !mr && !fl;
        prev_data = m_data;
        last_in   = in_x && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (out_x && sb.size() > 0) void'(sb.pop_front());
            if (in_x) sb.push_back(sd);
        end
    endtask

    // Five back-to-back items into an empty pipe with the sink always ready:
    // item n (1-based) must be on the output in cycle n+2.
    task automatic runLatency();
        for (int i = 0; i < 10; i++) begin
            stepCycle(i < 5, W'(i + 1), 1'b1, 1'b0,
                      (i >= ST && i < ST + 5) ? 1 : 0,
                      (i >= ST && i < ST + 5) ? i - ST + 1 : -1);
        end
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_occ", 32'(occupancy), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] latency and throughput");
        runLatency();

        $display("[TB] fill with sink stalled, then drain");
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycle(1'b1, W'(8'hA0 + acc), 1'b0, 1'b0, -1, -1);
            if (last_in) acc++;
        end
        checkOutput("fill_count", 32'(acc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            stepCycle(1'b0, '0, 1'b1, 1'b0, (i < 3) ? 1 : 0,
                      (i < 3) ? 32'h A0 + i : -1);
        end

        $display("[TB] flush on a full pipe");
        for (int i = 0; i < 3; i++) stepCycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0, -1, -1);
        stepCycle(1'b1, 8'hEE, 1'b0, 1'b1, 1, -1);
        for (int i = 0; i < 4; i++) stepCycle(1'b0, '0, 1'b1, 1'b0, 0, -1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            stepCycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 9) < 6,
                      $urandom_range(0, 49) == 0, -1, -1);
        end
        for (int i = 0; i < 6; i++) stepCycle(1'b0, '0, 1'b1, 1'b0, -1, -1);
        checkOutput("drain_occ", 32'(occupancy), 32'd0);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 2; i++) stepCycle(1'b1, W'(8'h50 + i), 1'b0, 1'b0, -1, -1);
        stepCycle(1'b1, 8'h52, 1'b0, 1'b0, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("arst_m_data", 32'(m_data), 32'd0);
        checkOutput("arst_occ", 32'(occupancy), 32'd0);
        checkOutput("arst_s_ready", 32'(s_ready), 32'd1);
        sb.delete();
        prev_hold = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runLatency();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
